// File: rtl/mux_8_rr.sv
// mux_8_rr: gathers eight valid/ready source streams into one registered
// sink stream using round-robin arbitration, tagging each beat with its
// source index on sel_o.
// Optional feature: define MUX_8_RR_PKT_LOCK_EN to add last_k_i/last_o and
// hold the grant on one source until its end-of-packet beat is accepted.
module mux_8_rr #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_0_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  input  logic [DATA_WIDTH-1:0] data_2_i,
  input  logic [DATA_WIDTH-1:0] data_3_i,
  input  logic [DATA_WIDTH-1:0] data_4_i,
  input  logic [DATA_WIDTH-1:0] data_5_i,
  input  logic [DATA_WIDTH-1:0] data_6_i,
  input  logic [DATA_WIDTH-1:0] data_7_i,
  input  logic                  valid_0_i,
  input  logic                  valid_1_i,
  input  logic                  valid_2_i,
  input  logic                  valid_3_i,
  input  logic                  valid_4_i,
  input  logic                  valid_5_i,
  input  logic                  valid_6_i,
  input  logic                  valid_7_i,
  output logic                  ready_0_o,
  output logic                  ready_1_o,
  output logic                  ready_2_o,
  output logic                  ready_3_o,
  output logic                  ready_4_o,
  output logic                  ready_5_o,
  output logic                  ready_6_o,
  output logic                  ready_7_o,
`ifdef MUX_8_RR_PKT_LOCK_EN
  input  logic                  last_0_i,
  input  logic                  last_1_i,
  input  logic                  last_2_i,
  input  logic                  last_3_i,
  input  logic                  last_4_i,
  input  logic                  last_5_i,
  input  logic                  last_6_i,
  input  logic                  last_7_i,
  output logic                  last_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [2:0]            sel_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  logic [DATA_WIDTH-1:0] data_arr [8];
  logic [7:0]            valid_vec;
  logic [7:0]            ready_vec;
  logic [2:0]            ptr;
  logic                  slot_free;
  logic [2:0]            scan_idx;
  logic [2:0]            scan_winner;
  logic                  scan_found;
  logic [2:0]            winner;
  logic                  have_winner;
  logic                  accept;

`ifdef MUX_8_RR_PKT_LOCK_EN
  logic [7:0]            last_vec;
  logic                  locked;
  logic [2:0]            lock_idx;

  assign last_vec = {last_7_i, last_6_i, last_5_i, last_4_i,
                     last_3_i, last_2_i, last_1_i, last_0_i};
`endif

  assign data_arr[0] = data_0_i;
  assign data_arr[1] = data_1_i;
  assign data_arr[2] = data_2_i;
  assign data_arr[3] = data_3_i;
  assign data_arr[4] = data_4_i;
  assign data_arr[5] = data_5_i;
  assign data_arr[6] = data_6_i;
  assign data_arr[7] = data_7_i;

  assign valid_vec = {valid_7_i, valid_6_i, valid_5_i, valid_4_i,
                      valid_3_i, valid_2_i, valid_1_i, valid_0_i};

  assign slot_free = !valid_o || ready_i;

  // Priority scan starting at ptr: first valid source wins, wrapping past 7.
  always_comb begin
    scan_idx    = '0;
    scan_winner = '0;
    scan_found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr + 3'(i);
      if (!scan_found && valid_vec[scan_idx]) begin
        scan_found  = 1'b1;
        scan_winner = scan_idx;
      end
    end
  end

  // A held packet lock overrides the scan; otherwise the scan result wins.
  always_comb begin
    winner      = scan_winner;
    have_winner = scan_found;
`ifdef MUX_8_RR_PKT_LOCK_EN
    if (locked) begin
      winner      = lock_idx;
      have_winner = 1'b1;
    end
`endif
  end

  // Only the winner sees ready, and only when the slot can take a beat.
  always_comb begin
    ready_vec = '0;
    if (slot_free && have_winner && !rst_i) begin
      ready_vec[winner] = 1'b1;
    end
  end

  assign accept = slot_free && have_winner && !rst_i && valid_vec[winner];

  assign ready_0_o = ready_vec[0];
  assign ready_1_o = ready_vec[1];
  assign ready_2_o = ready_vec[2];
  assign ready_3_o = ready_vec[3];
  assign ready_4_o = ready_vec[4];
  assign ready_5_o = ready_vec[5];
  assign ready_6_o = ready_vec[6];
  assign ready_7_o = ready_vec[7];

  // Output slot, round-robin pointer and packet lock state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      data_o   <= '0;
      sel_o    <= '0;
      ptr      <= '0;
`ifdef MUX_8_RR_PKT_LOCK_EN
      last_o   <= 1'b0;
      locked   <= 1'b0;
      lock_idx <= '0;
`endif
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= data_arr[winner];
      sel_o   <= winner;
`ifdef MUX_8_RR_PKT_LOCK_EN
      last_o  <= last_vec[winner];
      if (last_vec[winner]) begin
        locked <= 1'b0;
        ptr    <= winner + 3'd1;
      end else begin
        locked   <= 1'b1;
        lock_idx <= winner;
      end
`else
      ptr     <= winner + 3'd1;
`endif
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_8_rr.sv
// tb_mux_8_rr: directed self-checking bench for mux_8_rr (DATA_WIDTH=8).
// Source k always carries payload 0x10+k, so each beat's data is implied by
// its index.
module tb_mux_8_rr;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] data [8];
  logic [7:0] valid;
  wire  [7:0] ready;
  logic [7:0] data_o;
  logic [2:0] sel_o;
  logic       valid_o;
  logic       ready_i;
`ifdef MUX_8_RR_PKT_LOCK_EN
  logic [7:0] last;
  logic       last_o;
`endif

  int check_count = 0;
  int pass_count  = 0;

  mux_8_rr #(.DATA_WIDTH(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_0_i  (data[0]),
    .data_1_i  (data[1]),
    .data_2_i  (data[2]),
    .data_3_i  (data[3]),
    .data_4_i  (data[4]),
    .data_5_i  (data[5]),
    .data_6_i  (data[6]),
    .data_7_i  (data[7]),
    .valid_0_i (valid[0]),
    .valid_1_i (valid[1]),
    .valid_2_i (valid[2]),
    .valid_3_i (valid[3]),
    .valid_4_i (valid[4]),
    .valid_5_i (valid[5]),
    .valid_6_i (valid[6]),
    .valid_7_i (valid[7]),
    .ready_0_o (ready[0]),
    .ready_1_o (ready[1]),
    .ready_2_o (ready[2]),
    .ready_3_o (ready[3]),
    .ready_4_o (ready[4]),
    .ready_5_o (ready[5]),
    .ready_6_o (ready[6]),
    .ready_7_o (ready[7]),
`ifdef MUX_8_RR_PKT_LOCK_EN
    .last_0_i  (last[0]),
    .last_1_i  (last[1]),
    .last_2_i  (last[2]),
    .last_3_i  (last[3]),
    .last_4_i  (last[4]),
    .last_5_i  (last[5]),
    .last_6_i  (last[6]),
    .last_7_i  (last[7]),
    .last_o    (last_o),
`endif
    .data_o    (data_o),
    .sel_o     (sel_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance past the next rising edge; inputs change here, outputs settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic rdy);
    valid   = v;
    ready_i = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Checks the registered beat currently presented on the sink side.
  task automatic checkBeat(input string tag, input int src);
    checkOutput({tag, " valid_o"}, 32'(valid_o), 32'd1);
    checkOutput({tag, " sel_o"},   32'(sel_o),   32'(src));
    checkOutput({tag, " data_o"},  32'(data_o),  32'h10 + 32'(src));
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) data[k] = 8'h10 + 8'(k);
`ifdef MUX_8_RR_PKT_LOCK_EN
    last = 8'hFF;
`endif
    rst_i = 1'b1;
    applyStimulus(8'h08, 1'b1);
    #1;

    // Reset holds everything idle even with a valid source and a ready sink.
    tick();
    tick();
    checkOutput("rst valid_o", 32'(valid_o), 32'd0);
    checkOutput("rst sel_o",   32'(sel_o),   32'd0);
    checkOutput("rst data_o",  32'(data_o),  32'd0);
    checkOutput("rst ready",   32'(ready),   32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("post-rst ready", 32'(ready), 32'h08);
    tick();
    checkBeat("post-rst beat", 3);
    applyStimulus(8'h00, 1'b1);
    tick();
    checkOutput("drain valid_o", 32'(valid_o), 32'd0);

    // Full contention: strict 0..7 rotation, no bubbles.
    doReset();
    applyStimulus(8'hFF, 1'b1);
    for (int c = 0; c < 16; c++) begin
      tick();
      checkBeat($sformatf("rr c%0d", c), c % 8);
    end

    // Sink stall after accepting source 5.
    doReset();
    applyStimulus(8'h20, 1'b1);
    tick();
    checkBeat("stall first", 5);
    applyStimulus(8'hFF, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("stall ready c%0d", c), 32'(ready), 32'd0);
      tick();
      checkBeat($sformatf("stall hold c%0d", c), 5);
    end
    applyStimulus(8'hFF, 1'b1);
    #1;
    checkOutput("unstall ready", 32'(ready), 32'h40);
    tick();
    checkBeat("unstall beat", 6);

    // Sparse sources 7 and 2 with ptr at 7: pointer wraps through 0.
    doReset();
    applyStimulus(8'h40, 1'b1);
    tick();
    checkBeat("sparse prep", 6);
    applyStimulus(8'h84, 1'b1);
    tick();
    checkBeat("sparse g0", 7);
    tick();
    checkBeat("sparse g1", 2);
    tick();
    checkBeat("sparse g2", 7);
    tick();
    checkBeat("sparse g3", 2);

    // Reset mid-transfer with the sink stalled discards the beat.
    applyStimulus(8'h10, 1'b1);
    tick();
    checkBeat("midrst beat", 4);
    applyStimulus(8'h00, 1'b0);
    tick();
    checkBeat("midrst hold", 4);
    doReset();
    checkOutput("midrst valid_o", 32'(valid_o), 32'd0);
    checkOutput("midrst sel_o",   32'(sel_o),   32'd0);
    checkOutput("midrst data_o",  32'(data_o),  32'd0);
    applyStimulus(8'hFF, 1'b1);
    #1;
    checkOutput("midrst ptr ready", 32'(ready), 32'h01);
    tick();
    checkBeat("midrst next", 0);

`ifdef MUX_8_RR_PKT_LOCK_EN
    // Packet lock: source 1 keeps the grant for its 3-beat packet.
    doReset();
    last = 8'hFF;
    applyStimulus(8'h01, 1'b1);
    tick();
    checkBeat("pkt single", 0);
    checkOutput("pkt single last", 32'(last_o), 32'd1);
    last[1] = 1'b0;
    applyStimulus(8'h03, 1'b1);
    tick();
    checkBeat("pkt b0", 1);
    checkOutput("pkt b0 last", 32'(last_o), 32'd0);
    checkOutput("pkt lock ready", 32'(ready), 32'h02);
    tick();
    checkBeat("pkt b1", 1);
    checkOutput("pkt b1 last", 32'(last_o), 32'd0);
    last[1] = 1'b1;
    tick();
    checkBeat("pkt b2", 1);
    checkOutput("pkt b2 last", 32'(last_o), 32'd1);
    applyStimulus(8'h05, 1'b1);
    tick();
    checkBeat("pkt after", 2);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mux_8_rr.md
# mux_8_rr

8-to-1 stream multiplexer with round-robin arbitration and a registered output stage. It is the gathering counterpart of the 8-way demultiplexer: it merges eight valid/ready source channels into one sink channel and tags each beat with its source index. It sits in front of shared sinks such as a common FIFO, a serializer or a bus master.

## Interface

Parameters:
- DATA_WIDTH, 1, width of every data port.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- data_k_i (k = 0..7)  input  DATA_WIDTH  source k payload.
- valid_k_i (k = 0..7)  input  1  source k beat available.
- ready_k_o (k = 0..7)  output  1  source k beat accepted this cycle when high together with valid_k_i.
- last_k_i (k = 0..7)  input  1  source k end-of-packet. Present only with MUX_8_RR_PKT_LOCK_EN.
- data_o  output  DATA_WIDTH  registered selected payload.
- sel_o  output  3  registered source index of the beat on data_o.
- last_o  output  1  registered copy of last_k_i. Present only with MUX_8_RR_PKT_LOCK_EN.
- valid_o  output  1  output beat valid.
- ready_i  input  1  sink can take the beat.

## Operation

- Output stage:
  - One register slot holding data_o, sel_o, last_o and valid_o.
  - The slot is free when !valid_o || ready_i.
- Round-robin pointer ptr (3 bits):
  - The winner is the first k with valid_k_i high, scanning ptr, ptr+1, … ptr+7 mod 8.
  - Winner selection is combinational from registered ptr.
- Input handshake:
  - ready_k_o = slot_free && (k == winner) && !rst_i.
  - At most one ready_k_o is high per cycle.
  - ready_k_o never depends on ready_i through anything other than slot_free.
- On accept (valid_k_i && ready_k_o):
  - data_o <= data_k_i, sel_o <= k, valid_o <= 1.
  - ptr <= (k+1) mod 8. The increment wraps from 7 to 0.
- No accept, ready_i high: valid_o <= 0. data_o and sel_o hold their values.
- No accept, ready_i low: the output registers hold.
- Sink stall: while valid_o && !ready_i, all ready_k_o are 0, and data_o, sel_o and valid_o are stable. Sink-side AXI-style rule: the output never changes or drops while stalled.
- No valid source: ptr holds and the slot drains normally.
- A source must not retract valid_k_i before acceptance. The block does not check this.
- Reset (any cycle, including mid-transfer or with the sink stalled):
  - valid_o=0, data_o=0, sel_o=0, last_o=0, ptr=0, packet lock cleared.
  - The in-flight beat is discarded.
  - All ready_k_o are 0 while rst_i is high.

## Timing

- Latency: 1 cycle from the accept edge to valid_o high with that beat.
- Throughput: 1 beat per cycle when ready_i is held high.
- Fairness: with all 8 sources continuously valid and ready_i high, the grant order is 0,1,…,7,0,… Each source waits at most 7 beats between grants.
- Back-to-back: an accept and the sink consumption happen on the same edge, with no bubble.
- ready_i to ready_k_o: combinational path. valid_k_i to ready_k_o: combinational path through the priority scan.

## Configuration

- MUX_8_RR_PKT_LOCK_EN defined:
  - Adds last_k_i and last_o.
  - A lock flag and locked index are set on accepting a beat with last_k_i=0.
  - While locked, winner = locked index. Other sources get ready_k_o=0 even if the locked source is idle.
  - The lock clears on accepting its beat with last_k_i=1.
  - ptr advances only on accepting a last beat, to (k+1) mod 8.
  - Single-beat packets (last=1 on the first beat) never lock.
- MUX_8_RR_PKT_LOCK_EN undefined:
  - No last ports.
  - Arbitration is per beat, as described in Operation.

## Test plan

- Reset check: assert rst_i with valid_3_i=1 and ready_i=1 -> valid_o=0, sel_o=0, data_o=0, all ready_k_o=0. After release, the first accept is from source 3.
- Full contention: all valid_k_i=1, data_k_i=k+0x10, ready_i=1 for 16 cycles -> sel_o sequence 0..7,0..7 with data_o=0x10..0x17. valid_o is high continuously from cycle 1.
- Sink stall: source 5 accepted, then ready_i=0 for 4 cycles -> data_o and sel_o=5 are held, all ready_k_o=0. Release -> the next winner is source 6 if valid.
- Wrap and sparse sources: only sources 7 and 2 valid, ptr=7 -> grants 7,2,7,2. The pointer wraps 7 to 0 correctly.
- Reset mid-transfer: valid_o=1 with the sink stalled, then pulse rst_i for 1 cycle -> valid_o=0 on the next cycle. The beat is lost and ptr=0.
- With MUX_8_RR_PKT_LOCK_EN: source 1 sends a 3-beat packet while source 0 is continuously valid -> sel_o=1,1,1 with last_o only on the third beat, then source 2..7 or 0 per the pointer.
